// File: rtl/pmod_pkg.sv
// Shared constants for the PMOD serial converter paths (ADC capture, DAC drive).
package pmod_pkg;
  typedef logic [1:0] pmod_state_t;

  localparam pmod_state_t ST_IDLE  = 2'd0;
  localparam pmod_state_t ST_SETUP = 2'd1;
  localparam pmod_state_t ST_SHIFT = 2'd2;
  localparam pmod_state_t ST_QUIET = 2'd3;

  localparam int PMOD_FRAME_BITS = 16;
  localparam int PMOD_RESOLUTION = 12;
endpackage

// File: rtl/pmod_sclk_gen.sv
// Serial clock divider: registered SCLK idling high, CLK_DIV clk cycles per half period.
module pmod_sclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sclk,
  output logic rise,
  output logic fall
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;
  logic          tc;

  // Strobes mark the cycle whose closing edge toggles sclk.
  assign tc   = en && (cnt == '0);
  assign rise = tc && !sclk;
  assign fall = tc && sclk;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      sclk <= 1'b1;
      cnt  <= CW'(CLK_DIV - 1);
    end else if (tc) begin
      sclk <= ~sclk;
      cnt  <= CW'(CLK_DIV - 1);
    end else begin
      cnt <= cnt - CW'(1);
    end
  end
endmodule

// File: rtl/pmod_adc_block.sv
// Two-channel PMOD ADC frame capture. Optional leading-bit check: PMOD_ADC_LEADING_ZERO_CHECK_EN.
//   state | meaning
//   IDLE  | CS high, waiting for start
//   SETUP | CS low, SCLK high before first fall
//   SHIFT | SCLK running, sample both channels on each rise
//   QUIET | CS high recovery before next frame
module pmod_adc_block
  import pmod_pkg::*;
#(
  parameter int RESOLUTION   = PMOD_RESOLUTION,
  parameter int FRAME_BITS   = PMOD_FRAME_BITS,
  parameter int CLK_DIV      = 4,
  parameter int QUIET_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic [RESOLUTION-1:0] dout0,
  output logic [RESOLUTION-1:0] dout1,
  output logic                  dout_valid,
`ifdef PMOD_ADC_LEADING_ZERO_CHECK_EN
  output logic                  frame_err,
`endif
  output logic                  adc_cs_n,
  output logic                  adc_sclk,
  input  logic                  adc_sdata0,
  input  logic                  adc_sdata1
);
  localparam int BCW  = $clog2(FRAME_BITS + 1);
  localparam int TMAX = (CLK_DIV > QUIET_CYCLES) ? CLK_DIV : QUIET_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
`ifdef PMOD_ADC_LEADING_ZERO_CHECK_EN
  localparam int SRW  = FRAME_BITS;
`else
  localparam int SRW  = RESOLUTION;
`endif

  pmod_state_t     state;
  logic [BCW-1:0]  bit_cnt;
  logic [TW-1:0]   tmr;
  logic [SRW-1:0]  sr0, sr1;
  logic            gen_en, sclk_rise, sclk_fall, last_bit;

  assign last_bit = (bit_cnt == BCW'(FRAME_BITS));
  // The divider stops after the last rise; the final high half is timed by tmr.
  assign gen_en   = (state == ST_SETUP) || ((state == ST_SHIFT) && !last_bit);

  pmod_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (gen_en),
    .sclk (adc_sclk),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      adc_cs_n   <= 1'b1;
      dout_valid <= 1'b0;
      dout0      <= '0;
      dout1      <= '0;
      bit_cnt    <= '0;
      tmr        <= '0;
      sr0        <= '0;
      sr1        <= '0;
`ifdef PMOD_ADC_LEADING_ZERO_CHECK_EN
      frame_err  <= 1'b0;
`endif
    end else begin
      dout_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_SETUP;
            busy     <= 1'b1;
            adc_cs_n <= 1'b0;
            bit_cnt  <= '0;
          end
        end
        ST_SETUP: begin
          if (sclk_fall) state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (sclk_rise) begin
            sr0     <= (sr0 << 1) | SRW'(adc_sdata0);
            sr1     <= (sr1 << 1) | SRW'(adc_sdata1);
            bit_cnt <= bit_cnt + BCW'(1);
            tmr     <= TW'(CLK_DIV - 1);
          end else if (last_bit) begin
            if (tmr == '0) begin
              state      <= ST_QUIET;
              adc_cs_n   <= 1'b1;
              dout0      <= sr0[RESOLUTION-1:0];
              dout1      <= sr1[RESOLUTION-1:0];
              dout_valid <= 1'b1;
              tmr        <= TW'(QUIET_CYCLES - 1);
`ifdef PMOD_ADC_LEADING_ZERO_CHECK_EN
              if ((|(sr0 >> RESOLUTION)) || (|(sr1 >> RESOLUTION))) frame_err <= 1'b1;
`endif
            end else begin
              tmr <= tmr - TW'(1);
            end
          end
        end
        ST_QUIET: begin
          if (tmr == '0) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            tmr <= tmr - TW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pmod_adc_block.sv
// Self-checking bench for pmod_adc_block: default instance plus a CLK_DIV=1/QUIET_CYCLES=1 instance.
module tb_pmod_adc_block;
  localparam int FB = 16;
  localparam int QC = 8;
  localparam int T_VALID   = 1 + 4 + 2 * FB * 4;
  localparam int T_IDLE    = T_VALID + QC;
  localparam int T_VALID_C = 1 + 1 + 2 * FB * 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, sdata0 = 1'b0, sdata1 = 1'b0;
  logic busy, dout_valid, adc_cs_n, adc_sclk;
  logic [11:0] dout0, dout1;
  logic start_c = 1'b0, sd0_c = 1'b0, sd1_c = 1'b0;
  logic busy_c, valid_c, cs_c, sclk_c;
  logic [11:0] d0_c, d1_c;
`ifdef PMOD_ADC_LEADING_ZERO_CHECK_EN
  logic frame_err, frame_err_c;
`endif

  pmod_adc_block dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy),
    .dout0(dout0), .dout1(dout1), .dout_valid(dout_valid),
`ifdef PMOD_ADC_LEADING_ZERO_CHECK_EN
    .frame_err(frame_err),
`endif
    .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk),
    .adc_sdata0(sdata0), .adc_sdata1(sdata1)
  );

  pmod_adc_block #(.CLK_DIV(1), .QUIET_CYCLES(1)) dut_c (
    .clk(clk), .rst(rst), .start(start_c), .busy(busy_c),
    .dout0(d0_c), .dout1(d1_c), .dout_valid(valid_c),
`ifdef PMOD_ADC_LEADING_ZERO_CHECK_EN
    .frame_err(frame_err_c),
`endif
    .adc_cs_n(cs_c), .adc_sclk(sclk_c),
    .adc_sdata0(sd0_c), .adc_sdata1(sd1_c)
  );

  always #5 clk = ~clk;

  int compared = 0, mismatched = 0;
  int cyc = 0, t0 = 0;
  int valid_cnt = 0, rise_cnt = 0, rise_cnt_c = 0;
  logic err_exp = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (dout_valid === 1'b1) valid_cnt++;
  always @(posedge adc_sclk) if (adc_cs_n === 1'b0) rise_cnt++;
  always @(posedge sclk_c) if (cs_c === 1'b0) rise_cnt_c++;

  // ADC model: each frame takes the next queued word, presents bit (FB-k) after SCLK fall k.
  logic [15:0] q0[$], q1[$], qc0[$], qc1[$];
  logic [15:0] w0, w1, wc0, wc1;
  int idx = 0, idx_c = 0;

  always @(negedge adc_cs_n) begin
    w0 = (q0.size() > 0) ? q0.pop_front() : 16'h0000;
    w1 = (q1.size() > 0) ? q1.pop_front() : 16'h0000;
    idx = FB;
  end
  always @(negedge adc_sclk) if (adc_cs_n === 1'b0 && idx > 0) begin
    idx--;
    sdata0 = w0[idx];
    sdata1 = w1[idx];
  end
  always @(negedge cs_c) begin
    wc0 = (qc0.size() > 0) ? qc0.pop_front() : 16'h0000;
    wc1 = (qc1.size() > 0) ? qc1.pop_front() : 16'h0000;
    idx_c = FB;
  end
  always @(negedge sclk_c) if (cs_c === 1'b0 && idx_c > 0) begin
    idx_c--;
    sd0_c = wc0[idx_c];
    sd1_c = wc1[idx_c];
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wait_until(input int rel);
    while (cyc < t0 + rel) @(negedge clk);
  endtask

  task automatic begin_frame();
    @(negedge clk);
    start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid(output int t, input int limit);
    t = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (dout_valid === 1'b1) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) begin
      compared++;
      mismatched++;
      $display("FAIL valid_timeout: no dout_valid within %0d cycles", limit);
    end
  endtask

  function automatic logic lead_bad(input logic [15:0] a, input logic [15:0] b);
    return (a[15:12] != 4'h0) || (b[15:12] != 4'h0);
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    tick(4);
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL rst_busy: got %b want 0", busy); end
    compared++; if (dout0 !== 12'h000) begin mismatched++; $display("FAIL rst_dout0: got %h want 000", dout0); end
    compared++; if (dout1 !== 12'h000) begin mismatched++; $display("FAIL rst_dout1: got %h want 000", dout1); end
    compared++; if (dout_valid !== 1'b0) begin mismatched++; $display("FAIL rst_valid: got %b want 0", dout_valid); end
    compared++; if (adc_cs_n !== 1'b1) begin mismatched++; $display("FAIL rst_cs: got %b want 1", adc_cs_n); end
    compared++; if (adc_sclk !== 1'b1) begin mismatched++; $display("FAIL rst_sclk: got %b want 1", adc_sclk); end
`ifdef PMOD_ADC_LEADING_ZERO_CHECK_EN
    compared++; if (frame_err !== 1'b0) begin mismatched++; $display("FAIL rst_err: got %b want 0", frame_err); end
`endif
    rst = 1'b0;
    err_exp = 1'b0;
    tick(2);
  endtask

  task automatic test_single_frame();
    int t;
    q0.push_back(16'h0ABC);
    q1.push_back(16'h0123);
    rise_cnt = 0;
    begin_frame();
    compared++; if (adc_cs_n !== 1'b0 || busy !== 1'b1) begin mismatched++; $display("FAIL edge1_cs_busy: got cs=%b busy=%b want cs=0 busy=1", adc_cs_n, busy); end
    wait_valid(t, 300);
    compared++; if (t - t0 !== T_VALID) begin mismatched++; $display("FAIL single_valid_edge: got %0d want %0d", t - t0, T_VALID); end
    compared++; if (dout0 !== 12'hABC) begin mismatched++; $display("FAIL single_dout0: got %h want abc", dout0); end
    compared++; if (dout1 !== 12'h123) begin mismatched++; $display("FAIL single_dout1: got %h want 123", dout1); end
    compared++; if (rise_cnt !== FB) begin mismatched++; $display("FAIL single_rises: got %0d want %0d", rise_cnt, FB); end
    compared++; if (adc_cs_n !== 1'b1) begin mismatched++; $display("FAIL single_cs_end: got %b want 1", adc_cs_n); end
    tick(1);
    compared++; if (dout_valid !== 1'b0) begin mismatched++; $display("FAIL single_valid_width: got %b want 0", dout_valid); end
    wait_until(T_IDLE - 1);
    compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL single_busy_quiet: got %b want 1", busy); end
    wait_until(T_IDLE);
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL single_busy_idle: got %b want 0", busy); end
  endtask

  task automatic test_ignored_start();
    logic [15:0] a, b;
    int vc;
    a = 16'($urandom_range(0, 4095));
    b = 16'($urandom_range(0, 4095));
    q0.push_back(a);
    q1.push_back(b);
    vc = valid_cnt;
    begin_frame();
    wait_until(49); start = 1'b1;
    wait_until(50); start = 1'b0;
    wait_until(134); start = 1'b1;
    wait_until(135); start = 1'b0;
    wait_until(T_IDLE - 1);
    compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL ign_busy_140: got %b want 1", busy); end
    wait_until(T_IDLE);
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL ign_busy_141: got %b want 0", busy); end
    tick(6);
    compared++; if (busy !== 1'b0 || adc_cs_n !== 1'b1) begin mismatched++; $display("FAIL ign_no_refire: got busy=%b cs=%b want 0/1", busy, adc_cs_n); end
    compared++; if (valid_cnt - vc !== 1) begin mismatched++; $display("FAIL ign_valid_count: got %0d want 1", valid_cnt - vc); end
    compared++; if (dout0 !== a[11:0] || dout1 !== b[11:0]) begin mismatched++; $display("FAIL ign_data: got %h/%h want %h/%h", dout0, dout1, a[11:0], b[11:0]); end
  endtask

  task automatic test_back_to_back();
    int ta, tb, gap;
    logic [15:0] b1, b2;
    b1 = 16'($urandom_range(0, 4095));
    b2 = 16'($urandom_range(0, 4095));
    q0.push_back(16'h0FFF); q1.push_back(b1);
    q0.push_back(16'h0000); q1.push_back(b2);
    @(negedge clk);
    start = 1'b1;
    wait_valid(ta, 300);
    compared++; if (dout0 !== 12'hFFF || dout1 !== b1[11:0]) begin mismatched++; $display("FAIL b2b_first: got %h/%h want fff/%h", dout0, dout1, b1[11:0]); end
    gap = 0;
    while (adc_cs_n === 1'b1 && gap < 50) begin
      @(negedge clk);
      gap++;
    end
    compared++; if (gap < QC || gap >= 50) begin mismatched++; $display("FAIL b2b_cs_gap: got %0d want >=%0d", gap, QC); end
    wait_valid(tb, 300);
    start = 1'b0;
    compared++; if (tb - ta !== T_IDLE) begin mismatched++; $display("FAIL b2b_spacing: got %0d want %0d", tb - ta, T_IDLE); end
    compared++; if (dout0 !== 12'h000 || dout1 !== b2[11:0]) begin mismatched++; $display("FAIL b2b_second: got %h/%h want 000/%h", dout0, dout1, b2[11:0]); end
    tick(QC + 4);
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL b2b_stop: got busy %b want 0", busy); end
  endtask

  task automatic test_reset_mid_frame();
    int t, vc;
    logic [15:0] c;
    q0.push_back(16'h05A5); q1.push_back(16'h0000);
    begin_frame();
    wait_valid(t, 300);
    compared++; if (dout0 !== 12'h5A5) begin mismatched++; $display("FAIL rmf_prior: got %h want 5a5", dout0); end
    tick(QC + 2);
    q0.push_back(16'($urandom_range(0, 4095))); q1.push_back(16'($urandom_range(0, 4095)));
    begin_frame();
    wait_until(59); rst = 1'b1;
    wait_until(60);
    vc = valid_cnt;
    compared++; if (adc_cs_n !== 1'b1 || adc_sclk !== 1'b1) begin mismatched++; $display("FAIL rmf_pins: got cs=%b sclk=%b want 1/1", adc_cs_n, adc_sclk); end
    compared++; if (dout0 !== 12'h000 || busy !== 1'b0) begin mismatched++; $display("FAIL rmf_state: got dout0=%h busy=%b want 000/0", dout0, busy); end
    rst = 1'b0;
    err_exp = 1'b0;
    tick(T_VALID);
    compared++; if (valid_cnt !== vc) begin mismatched++; $display("FAIL rmf_no_valid: got %0d pulses want 0", valid_cnt - vc); end
    c = 16'($urandom_range(0, 4095));
    q0.push_back(c); q1.push_back(16'h0FED);
    begin_frame();
    wait_valid(t, 300);
    compared++; if (t - t0 !== T_VALID || dout0 !== c[11:0] || dout1 !== 12'hFED) begin mismatched++; $display("FAIL rmf_recover: got t=%0d %h/%h want %0d %h/fed", t - t0, dout0, dout1, T_VALID, c[11:0]); end
    tick(QC + 2);
  endtask

  task automatic test_random_frames();
    int t;
    logic [15:0] a, b;
    for (int n = 0; n < 5; n++) begin
      a = 16'($urandom_range(0, 4095));
      b = 16'($urandom_range(0, 4095));
      q0.push_back(a); q1.push_back(b);
      err_exp = err_exp | lead_bad(a, b);
      begin_frame();
      wait_valid(t, 300);
      compared++; if (t - t0 !== T_VALID || dout0 !== a[11:0] || dout1 !== b[11:0]) begin mismatched++; $display("FAIL rand_frame%0d: got t=%0d %h/%h want %0d %h/%h", n, t - t0, dout0, dout1, T_VALID, a[11:0], b[11:0]); end
`ifdef PMOD_ADC_LEADING_ZERO_CHECK_EN
      compared++; if (frame_err !== err_exp) begin mismatched++; $display("FAIL rand_err%0d: got %b want %b", n, frame_err, err_exp); end
`endif
      wait_until(T_IDLE + 1);
    end
  endtask

  task automatic test_leading_bits();
    int t;
    logic [15:0] a;
    q0.push_back(16'h0ABC); q1.push_back(16'h8123);
    err_exp = err_exp | lead_bad(16'h0ABC, 16'h8123);
    begin_frame();
    wait_valid(t, 300);
    compared++; if (dout1 !== 12'h123 || dout0 !== 12'hABC) begin mismatched++; $display("FAIL lead_data: got %h/%h want abc/123", dout0, dout1); end
`ifdef PMOD_ADC_LEADING_ZERO_CHECK_EN
    compared++; if (frame_err !== err_exp) begin mismatched++; $display("FAIL lead_err: got %b want %b", frame_err, err_exp); end
`endif
    wait_until(T_IDLE + 1);
    a = 16'($urandom_range(0, 4095));
    q0.push_back(a); q1.push_back(16'h0456);
    begin_frame();
    wait_valid(t, 300);
    compared++; if (dout0 !== a[11:0] || dout1 !== 12'h456) begin mismatched++; $display("FAIL lead_clean_data: got %h/%h want %h/456", dout0, dout1, a[11:0]); end
`ifdef PMOD_ADC_LEADING_ZERO_CHECK_EN
    compared++; if (frame_err !== err_exp) begin mismatched++; $display("FAIL lead_sticky: got %b want %b", frame_err, err_exp); end
`endif
    wait_until(T_IDLE + 1);
  endtask

  task automatic test_divider_corner();
    int t;
    logic [15:0] a, b;
    for (int n = 0; n < 2; n++) begin
      a = 16'($urandom_range(0, 4095));
      b = 16'($urandom_range(0, 4095));
      qc0.push_back(a); qc1.push_back(b);
      rise_cnt_c = 0;
      @(negedge clk);
      start_c = 1'b1;
      t0 = cyc;
      @(negedge clk);
      start_c = 1'b0;
      t = -1;
      for (int i = 0; i < 100; i++) begin
        if (valid_c === 1'b1) begin t = cyc; break; end
        @(negedge clk);
      end
      compared++; if (t - t0 !== T_VALID_C) begin mismatched++; $display("FAIL corner_valid_edge%0d: got %0d want %0d", n, t - t0, T_VALID_C); end
      compared++; if (d0_c !== a[11:0] || d1_c !== b[11:0]) begin mismatched++; $display("FAIL corner_data%0d: got %h/%h want %h/%h", n, d0_c, d1_c, a[11:0], b[11:0]); end
      compared++; if (rise_cnt_c !== FB) begin mismatched++; $display("FAIL corner_rises%0d: got %0d want %0d", n, rise_cnt_c, FB); end
      wait_until(T_VALID_C + 1);
      compared++; if (busy_c !== 1'b0) begin mismatched++; $display("FAIL corner_idle%0d: got %b want 0", n, busy_c); end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid_frame();
    test_random_frames();
    test_leading_bits();
    test_divider_corner();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/pmod_adc_block.md
# pmod_adc_block

Serial-capture controller for a two-channel PMOD ADC (AD7476A-class, 12-bit, 16-clock frames). It is the receive-side counterpart of the PMOD DAC path. On a `start` request it drives chip-select and a divided serial clock, then shifts in one frame per channel in parallel. It presents both conversion results to the SoC with a one-cycle valid strobe.

## Interface
- `RESOLUTION`, default 12: result width per channel.
- `FRAME_BITS`, default 16: SCLK rising edges per frame. The frame carries `FRAME_BITS-RESOLUTION` leading bits, then the result MSB first. Must be ≥ `RESOLUTION`.
- `CLK_DIV`, default 4: SCLK half-period in `clk` cycles. Must be ≥1.
- `QUIET_CYCLES`, default 8: minimum `clk` cycles with CS high between frames. Must be ≥1.

Ports:
- `clk` input, 1 bit: system clock. Single clock domain.
- `rst` input, 1 bit: reset, synchronous, active-high.
- `start` input, 1 bit: conversion request. Sampled only in IDLE.
- `busy` output, 1 bit: high whenever the state is not IDLE.
- `dout0` output, `RESOLUTION` bits: last channel-0 result.
- `dout1` output, `RESOLUTION` bits: last channel-1 result.
- `dout_valid` output, 1 bit: one-cycle pulse when `dout0`/`dout1` update.
- `frame_err` output, 1 bit: sticky leading-bit error flag. Present only under the macro; see Configuration.
- `adc_cs_n` output, 1 bit: chip-select, active-low.
- `adc_sclk` output, 1 bit: serial clock. Registered. Idles high.
- `adc_sdata0` input, 1 bit: channel-0 serial data.
- `adc_sdata1` input, 1 bit: channel-1 serial data.

## Operation
- **States:** IDLE, SETUP, SHIFT, QUIET. The encoding is a 2-bit localparam set.
- **IDLE:** `adc_cs_n`=1, `adc_sclk`=1. If `start`=1, go to SETUP.
- **SETUP:** `adc_cs_n`=0, `adc_sclk`=1 for `CLK_DIV` cycles. Then go to SHIFT.
- **SHIFT:**
  - `adc_sclk` drives low for `CLK_DIV` cycles, then high for `CLK_DIV` cycles. This repeats `FRAME_BITS` times.
  - The ADC changes data on the falling edges of SCLK.
  - On the `clk` edge that sets `adc_sclk` from 0 to 1, both `adc_sdata*` are shifted into per-channel shift registers, left-shift, LSB in.
  - A bit counter of width `$clog2(FRAME_BITS+1)` counts rising edges.
- **End of frame:** after the high half that follows rising edge `FRAME_BITS`:
  - `adc_cs_n` goes to 1.
  - `dout0`/`dout1` load the low `RESOLUTION` bits of the shift registers.
  - `dout_valid` pulses high for one cycle.
  - The state goes to QUIET.
- **QUIET:** `adc_cs_n`=1, `adc_sclk`=1 for `QUIET_CYCLES` cycles. Then go to IDLE.
- **`start` outside IDLE:** ignored, not queued.
- **`start` held high continuously:** back-to-back frames run, separated only by QUIET and one IDLE cycle.
- **`dout*` retention:** both outputs hold their value until the next completed frame. A frame aborted by reset never updates them.

## Timing
- **Reset values:** `busy`=0, `dout0`=`dout1`=0, `dout_valid`=0, `frame_err`=0, `adc_cs_n`=1, `adc_sclk`=1. State=IDLE and all counters are 0.
- **Reset mid-frame:** on the next edge, CS deasserts and SCLK returns high. No partial result is published.
- **Frame timeline:** `start` is sampled high at edge 0.
  - Edge 1: `adc_cs_n`=0, `busy`=1.
  - Edge 1+`CLK_DIV`: first SCLK fall.
  - Edge 1+`CLK_DIV`+2·k·`CLK_DIV`−`CLK_DIV`: rising edge k (k=1..`FRAME_BITS`).
  - Edge 1+`CLK_DIV`+2·`FRAME_BITS`·`CLK_DIV`: `adc_cs_n`=1 and `dout_valid`=1.
  - With defaults: rising edges at edges 9, 17, …, 129; `dout_valid` at edge 133.
- **Idle return:** `busy` drops `QUIET_CYCLES` cycles after `dout_valid`, which is edge 141 with defaults. The earliest next `start` can be sampled at that edge.
- **SCLK frequency:** `clk`/(2·`CLK_DIV`).
- **Interface outputs:** all registered; no combinational path from inputs.

## Configuration
- **Macro:** `PMOD_ADC_LEADING_ZERO_CHECK_EN`.
- **When defined:**
  - At end of frame, if any of the `FRAME_BITS-RESOLUTION` leading bits on either channel is 1, `frame_err` is set.
  - `frame_err` stays set until `rst`.
  - `dout*` and `dout_valid` still update normally.
- **When undefined:** the leading bits are discarded unchecked. The `frame_err` port and its logic are absent.

## Structure
- **Shared package `pmod_pkg`:** holds the state localparams (IDLE/SETUP/SHIFT/QUIET) and the default frame constants (16 frame bits, 12 result bits). The DAC block may reuse these.
- **Sub-module `pmod_sclk_gen`:** divider that produces registered SCLK plus one-cycle `rise` and `fall` strobes. It has an enable and is synchronous-reset to SCLK-high. The per-channel shift registers stay in the top module.

## Test plan
- **Single frame:** defaults. Model serves ch0 `0x0ABC` and ch1 `0x0123`, changing data on SCLK falls. Pulse `start` → `dout0`=`0xABC`, `dout1`=`0x123`, `dout_valid` pulses exactly at edge 133, and exactly 16 SCLK rising edges occur while CS is low.
- **Back-to-back:** hold `start` high. Model serves ch0 `0x0FFF` then `0x0000`. Expect two `dout_valid` pulses 141 cycles apart, CS high for ≥8 cycles between frames, and `dout0` values `0xFFF` then `0x000`.
- **Ignored start:** pulse `start` at edges 50 and 135 of a frame → no extra frame starts; `busy` falls at edge 141.
- **Reset mid-frame:** assert `rst` at edge 60, after a prior result `0x5A5` → CS=1 and SCLK=1 on the next edge. `dout0` is cleared to 0, `dout_valid` never pulses, and a following `start` completes normally.
- **Leading-bit error:** with `PMOD_ADC_LEADING_ZERO_CHECK_EN` defined, ch1 serves `0x8123` → `dout1`=`0x123`, `frame_err`=1 and sticky through a following clean frame. With the macro undefined, the same stimulus gives `dout1`=`0x123` and no error port.
- **Divider corner:** `CLK_DIV`=1, `QUIET_CYCLES`=1 → SCLK toggles every cycle, `dout_valid` at edge 34, and the result matches the model.
